// File: rtl/distinct_list_serializer.sv
// Snapshots the 4-entry "last distinct values" list on request and streams the
// valid prefix of that list, one entry per beat, over a valid/ready master port.
module distinct_list_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] list_0,
  input  logic [DATA_W-1:0] list_1,
  input  logic [DATA_W-1:0] list_2,
  input  logic [DATA_W-1:0] list_3,
  input  logic              list_valid_0,
  input  logic              list_valid_1,
  input  logic              list_valid_2,
  input  logic              list_valid_3,
  input  logic              req_in,
  input  logic              order_in,
  output logic [DATA_W-1:0] m_data_out,
  output logic [1:0]        m_idx_out,
  output logic              m_last_out,
  output logic              m_valid_out,
  input  logic              m_ready_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              empty_out
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] snap [4];
  logic [2:0]        cnt_q;
  logic              order_q;

  logic [2:0]        req_cnt;
  logic [2:0]        req_cnt_m1;
  logic [1:0]        first_idx;
  logic [DATA_W-1:0] first_data;
  logic              first_last;
  logic [2:0]        cnt_m1;
  logic [1:0]        end_idx;
  logic [1:0]        next_idx;
  logic              next_last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    req_cnt = 3'd0;
    if (list_valid_0) begin
      req_cnt = 3'd1;
      if (list_valid_1) begin
        req_cnt = 3'd2;
        if (list_valid_2) begin
          req_cnt = 3'd3;
          if (list_valid_3) req_cnt = 3'd4;
        end
      end
    end

    req_cnt_m1 = req_cnt - 3'd1;
    first_idx  = order_in ? req_cnt_m1[1:0] : 2'd0;
    first_last = (req_cnt == 3'd1);

    first_data = list_0;
    case (first_idx)
      2'd0:    first_data = list_0;
      2'd1:    first_data = list_1;
      2'd2:    first_data = list_2;
      default: first_data = list_3;
    endcase

    // Walk direction and terminal index come from the captured order, not the live input.
    cnt_m1    = cnt_q - 3'd1;
    end_idx   = order_q ? 2'd0 : cnt_m1[1:0];
    next_idx  = order_q ? (m_idx_out - 2'd1) : (m_idx_out + 2'd1);
    next_last = (next_idx == end_idx);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state       <= IDLE;
      cnt_q       <= 3'd0;
      order_q     <= 1'b0;
      m_data_out  <= '0;
      m_idx_out   <= 2'd0;
      m_last_out  <= 1'b0;
      m_valid_out <= 1'b0;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      empty_out   <= 1'b0;
      // NOTE: the snapshot is small and must read as cleared after reset, so it is reset like any register.
      for (int i = 0; i < 4; i++) snap[i] <= '0;
    end else begin
      done_out  <= 1'b0;
      empty_out <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in) begin
            if (req_cnt != 3'd0) begin
              snap[0]     <= list_0;
              snap[1]     <= list_1;
              snap[2]     <= list_2;
              snap[3]     <= list_3;
              order_q     <= order_in;
              cnt_q       <= req_cnt;
              state       <= SEND;
              busy_out    <= 1'b1;
              m_valid_out <= 1'b1;
              m_data_out  <= first_data;
              m_idx_out   <= first_idx;
              m_last_out  <= first_last;
            end else begin
              done_out  <= 1'b1;
              empty_out <= 1'b1;
            end
          end
        end
        SEND: begin
          // m_valid_out is always high in SEND, so ready alone completes the handshake.
          if (m_ready_in) begin
            if (m_last_out) begin
              state       <= IDLE;
              busy_out    <= 1'b0;
              done_out    <= 1'b1;
              m_valid_out <= 1'b0;
              m_data_out  <= '0;
              m_idx_out   <= 2'd0;
              m_last_out  <= 1'b0;
            end else begin
              m_idx_out  <= next_idx;
              m_data_out <= snap[next_idx];
              m_last_out <= next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_distinct_list_serializer.sv
// Scoreboard bench for distinct_list_serializer: expected beats are queued when a
// request is driven and compared at each handshake observed on the master port.
module tb_distinct_list_serializer;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        idx;
    logic              last;
  } beat_t;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic [DATA_W-1:0] list_0, list_1, list_2, list_3;
  logic              list_valid_0, list_valid_1, list_valid_2, list_valid_3;
  logic              req_in;
  logic              order_in;
  logic [DATA_W-1:0] m_data_out;
  logic [1:0]        m_idx_out;
  logic              m_last_out;
  logic              m_valid_out;
  logic              m_ready_in;
  logic              busy_out;
  logic              done_out;
  logic              empty_out;

  distinct_list_serializer #(.DATA_W(DATA_W)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .list_0       (list_0),
    .list_1       (list_1),
    .list_2       (list_2),
    .list_3       (list_3),
    .list_valid_0 (list_valid_0),
    .list_valid_1 (list_valid_1),
    .list_valid_2 (list_valid_2),
    .list_valid_3 (list_valid_3),
    .req_in       (req_in),
    .order_in     (order_in),
    .m_data_out   (m_data_out),
    .m_idx_out    (m_idx_out),
    .m_last_out   (m_last_out),
    .m_valid_out  (m_valid_out),
    .m_ready_in   (m_ready_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .empty_out    (empty_out)
  );

  always #5 clk_in = ~clk_in;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    hs_cyc = 0;
  int    done_seen = 0;
  int    rdy_mode = 0;  // 0: always ready, 1: toggle, 2: never ready
  beat_t sb [$];

  logic  prev_stall = 1'b0;
  logic  prev_done  = 1'b0;
  beat_t prev_beat  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_list(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [7:0] d3, input logic [3:0] v);
    list_0 = d0; list_1 = d1; list_2 = d2; list_3 = d3;
    list_valid_0 = v[0]; list_valid_1 = v[1]; list_valid_2 = v[2]; list_valid_3 = v[3];
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] i, input logic l);
    beat_t b;
    b.data = d; b.idx = i; b.last = l;
    sb.push_back(b);
  endtask

  task automatic pulse_req();
    req_in = 1'b1;
    tick();
    req_in = 1'b0;
  endtask

  // Bounded wait for the done pulse; returns at the falling edge where it was seen.
  task automatic wait_done(input string tag, input logic exp_empty);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_in);
      if (done_out) seen = 1'b1;
    end
    check({tag, "_done"}, {31'd0, seen}, 32'd1);
    if (seen) check({tag, "_empty"}, {31'd0, empty_out}, {31'd0, exp_empty});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, m_valid_out}, 32'd0);
    check({tag, "_beat"},  {21'd0, m_data_out, m_idx_out, m_last_out}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy_out}, 32'd0);
    check({tag, "_done"},  {31'd0, done_out}, 32'd0);
    check({tag, "_empty"}, {31'd0, empty_out}, 32'd0);
  endtask

  always @(posedge clk_in) cyc++;

  always @(posedge clk_in) begin
    #1;
    case (rdy_mode)
      0:       m_ready_in = 1'b1;
      1:       m_ready_in = ~m_ready_in;
      default: m_ready_in = 1'b0;
    endcase
  end

  // Monitor: checks stall stability, idle zeroing, done width and scoreboard order.
  always @(negedge clk_in) begin
    beat_t got;
    beat_t exp;
    got = {m_data_out, m_idx_out, m_last_out};
    if (!reset_in) begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_valid_out}, 32'd1);
        check("hold_beat", {21'd0, got}, {21'd0, prev_beat});
      end
      if (!m_valid_out) check("idle_zero", {21'd0, got}, 32'd0);
      if (m_valid_out && m_ready_in) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {21'd0, got}, 32'd0);
        end else begin
          exp = sb.pop_front();
          check("beat", {21'd0, got}, {21'd0, exp});
        end
        if (m_last_out) hs_cyc = cyc;
      end
      if (done_out) begin
        done_seen++;
        check("done_width", {31'd0, prev_done}, 32'd0);
      end
    end
    prev_stall = m_valid_out && !m_ready_in && !reset_in;
    prev_done  = done_out;
    prev_beat  = got;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    m_ready_in = 1'b1;
    req_in     = 1'b0;
    order_in   = 1'b0;
    set_list(8'd0, 8'd0, 8'd0, 8'd0, 4'b0000);
    reset_in = 1'b1;
    repeat (3) tick();
    check_all_zero("reset");
    reset_in = 1'b0;
    tick();

    // 1: two-entry list, newest first, always ready.
    set_list(8'd2, 8'd1, 8'hAA, 8'hBB, 4'b0011);
    order_in = 1'b0;
    push(8'd2, 2'd0, 1'b0);
    push(8'd1, 2'd1, 1'b1);
    pulse_req();
    check("t1_latency", {31'd0, m_valid_out}, 32'd1);
    check("t1_busy", {31'd0, busy_out}, 32'd1);
    wait_done("t1", 1'b0);
    check("t1_drained", sb.size(), 32'd0);
    tick();

    // 2: full list, oldest first, ready toggling.
    rdy_mode = 1;
    set_list(8'd3, 8'd4, 8'd2, 8'd1, 4'b1111);
    order_in = 1'b1;
    push(8'd1, 2'd3, 1'b0);
    push(8'd2, 2'd2, 1'b0);
    push(8'd4, 2'd1, 1'b0);
    push(8'd3, 2'd0, 1'b1);
    pulse_req();
    wait_done("t2", 1'b0);
    check("t2_drained", sb.size(), 32'd0);
    rdy_mode = 0;
    tick();
    tick();

    // 3: nothing valid -> immediate empty done, never busy.
    set_list(8'd9, 8'd9, 8'd9, 8'd9, 4'b0000);
    order_in = 1'b0;
    pulse_req();
    check("t3_valid", {31'd0, m_valid_out}, 32'd0);
    check("t3_busy", {31'd0, busy_out}, 32'd0);
    check("t3_done", {31'd0, done_out}, 32'd1);
    check("t3_empty", {31'd0, empty_out}, 32'd1);
    tick();
    check("t3_done_off", {31'd0, done_out}, 32'd0);
    check("t3_busy_off", {31'd0, busy_out}, 32'd0);
    tick();

    // 4: req held through SEND, list changes mid-transfer, re-trigger in the done cycle.
    set_list(8'd10, 8'd20, 8'd30, 8'd40, 4'b0111);
    order_in = 1'b0;
    push(8'd10, 2'd0, 1'b0);
    push(8'd20, 2'd1, 1'b0);
    push(8'd30, 2'd2, 1'b1);
    req_in = 1'b1;
    tick();
    set_list(8'd50, 8'd60, 8'd70, 8'd80, 4'b0011);
    push(8'd50, 2'd0, 1'b0);
    push(8'd60, 2'd1, 1'b1);
    wait_done("t4a", 1'b0);
    tick();
    req_in = 1'b0;
    check("t4_restart_valid", {31'd0, m_valid_out}, 32'd1);
    check("t4_restart_gap", cyc - hs_cyc, 32'd2);
    wait_done("t4b", 1'b0);
    check("t4_drained", sb.size(), 32'd0);
    tick();

    // 5: async reset between edges while a beat is stalled.
    rdy_mode = 2;
    tick();
    tick();
    set_list(8'd9, 8'd8, 8'd7, 8'd6, 4'b1111);
    order_in = 1'b0;
    pulse_req();
    tick();
    check("t5_stalled", {31'd0, m_valid_out}, 32'd1);
    #2;
    d0 = done_seen;
    reset_in = 1'b1;
    #1;
    check_all_zero("t5_async");
    repeat (2) tick();
    reset_in = 1'b0;
    rdy_mode = 0;
    tick();
    tick();
    check("t5_no_done", done_seen, d0);
    check("t5_idle", {31'd0, m_valid_out}, 32'd0);
    set_list(8'd11, 8'd12, 8'd0, 8'd0, 4'b0011);
    order_in = 1'b1;
    push(8'd12, 2'd1, 1'b0);
    push(8'd11, 2'd0, 1'b1);
    pulse_req();
    check("t5_restart", {31'd0, m_valid_out}, 32'd1);
    wait_done("t5", 1'b0);
    tick();

    // 6: broken valid prefix -> single beat.
    set_list(8'd5, 8'd6, 8'd7, 8'd8, 4'b1101);
    order_in = 1'b0;
    push(8'd5, 2'd0, 1'b1);
    pulse_req();
    wait_done("t6", 1'b0);
    check("t6_drained", sb.size(), 32'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
